// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and Status/Cause bit positions.
// Imported by the register file and its timer; holds no logic beyond one decode helper.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;

  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;
  localparam int CA_IPSW_LO = 8;
  localparam int CA_IPSW_HI = 9;
  localparam int CA_IPHW_LO = 10;
  localparam int CA_IPHW_HI = 15;
  localparam int CA_TI      = 30;
  localparam int CA_BD      = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count steps once every COUNT_DIV clocks, TI latches one cycle after a match.
// Writes take effect at the next edge; always accepts writes, no backpressure.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // The divider free-runs even across Count writes so the tick cadence is stable.
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      count   <= count_we ? wdata : count + 32'(tick);
      if (compare_we) begin
        compare <= wdata;
      end
      ti <= compare_we ? 1'b0 : (ti | (count == compare));
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 state holder: Status/Cause/EPC/BadVAddr plus timer; mfc0 reads are combinational, updates land next edge.
// Always accepts mtc0/exception/eret; same-cycle conflicts resolve as reset > exception > eret > mtc0.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtc0_we,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ex_valid,
  input  logic [4:0]  ex_code,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int,
  output logic [31:0] epc_out,
  output logic [31:0] exc_target,
  output logic        status_exl,
  output logic        int_req
);

  logic [31:0] badvaddr;
  logic [31:0] epc;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        exl;
  logic        cause_bd;
  logic [4:0]  cause_exc;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic        mtc0_go;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign mtc0_go = mtc0_we & ~ex_valid & ~eret;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_go && (rd == CP0_COUNT)),
    .compare_we (mtc0_go && (rd == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr    <= '0;
      epc         <= '0;
      status_im   <= '0;
      status_ie   <= 1'b0;
      exl         <= 1'b0;
      cause_bd    <= 1'b0;
      cause_exc   <= '0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
    end else begin
      // Timer interrupt shares IP7 with the highest hardware line.
      cause_ip_hw <= {ti | ext_int[5], ext_int[4:0]};
      if (ex_valid) begin
        if (!exl) begin
          epc      <= ex_bd ? ex_pc - 32'd4 : ex_pc;
          cause_bd <= ex_bd;
        end
        exl       <= 1'b1;
        cause_exc <= ex_code;
        if (is_addr_exc(ex_code)) begin
          badvaddr <= ex_badvaddr;
        end
      end else if (eret) begin
        exl <= 1'b0;
      end else if (mtc0_we) begin
        // BadVAddr is hardware-owned; an mtc0 to it is accepted and ignored.
        unique case (rd)
          CP0_STATUS: begin
            status_im <= wdata[ST_IM_HI:ST_IM_LO];
            exl       <= wdata[ST_EXL];
            status_ie <= wdata[ST_IE];
          end
          CP0_CAUSE: cause_ip_sw <= wdata[CA_IPSW_HI:CA_IPSW_LO];
          CP0_EPC:   epc         <= wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    status_rd                    = '0;
    status_rd[ST_BEV]            = 1'b1;
    status_rd[ST_IM_HI:ST_IM_LO] = status_im;
    status_rd[ST_EXL]            = exl;
    status_rd[ST_IE]             = status_ie;

    cause_rd                          = '0;
    cause_rd[CA_BD]                   = cause_bd;
    cause_rd[CA_TI]                   = ti;
    cause_rd[CA_IPHW_HI:CA_IPHW_LO]   = cause_ip_hw;
    cause_rd[CA_IPSW_HI:CA_IPSW_LO]   = cause_ip_sw;
    cause_rd[CA_EXC_HI:CA_EXC_LO]     = cause_exc;
  end

  always_comb begin
    rdata = '0;
    case (rd)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_rd;
      CP0_CAUSE:    rdata = cause_rd;
      CP0_EPC:      rdata = epc;
      default:      rdata = '0;
    endcase
  end

  assign epc_out    = epc;
  assign exc_target = EXC_VECTOR;
  assign status_exl = exl;
  assign int_req    = status_ie & ~exl & |({cause_ip_hw, cause_ip_sw} & status_im);

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomised plus directed bench for cp0_regfile with a word-level reference model and scoreboard.
module tb_cp0_regfile;

  localparam int COUNT_DIV = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mtc0_we = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_code = '0;
  logic [31:0] ex_pc = '0;
  logic        ex_bd = 1'b0;
  logic [31:0] ex_badvaddr = '0;
  logic        eret = 1'b0;
  logic [5:0]  ext_int = '0;
  logic [31:0] epc_out;
  logic [31:0] exc_target;
  logic        status_exl;
  logic        int_req;

  int errors = 0;
  int checks = 0;

  cp0_regfile #(.EXC_VECTOR(32'hBFC0_0380), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .rd(rd), .wdata(wdata), .rdata(rdata),
    .ex_valid(ex_valid), .ex_code(ex_code), .ex_pc(ex_pc), .ex_bd(ex_bd),
    .ex_badvaddr(ex_badvaddr), .eret(eret), .ext_int(ext_int), .epc_out(epc_out),
    .exc_target(exc_target), .status_exl(status_exl), .int_req(int_req)
  );

  always #5 clk = ~clk;

  // Reference model: whole architectural words, updated by the rules for each event.
  bit [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  int        m_phase;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        int_req;
    logic [31:0] epc;
    logic        exl;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  function automatic bit [31:0] model_read(input logic [4:0] r);
    case (r)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_int();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  task automatic model_step();
    bit        ti_old, hit, inc, wr, ti_new;
    bit [5:0]  ip_new;
    if (reset) begin
      m_badv = 0; m_count = 0; m_compare = 0; m_cause = 0; m_epc = 0;
      m_status = 32'h0040_0000; m_phase = 0;
      return;
    end
    ti_old  = m_cause[30];
    ip_new  = {ti_old | ext_int[5], ext_int[4:0]};
    hit     = (m_count == m_compare);
    inc     = (m_phase == COUNT_DIV - 1);
    m_phase = inc ? 0 : m_phase + 1;
    wr      = mtc0_we && !ex_valid && !eret;
    ti_new  = (wr && rd == 5'd11) ? 1'b0 : (ti_old | hit);
    m_count = (wr && rd == 5'd9) ? wdata : m_count + (inc ? 32'd1 : 32'd0);
    if (wr && rd == 5'd11) m_compare = wdata;
    if (ex_valid) begin
      if (!m_status[1]) begin
        m_epc = ex_bd ? ex_pc - 32'd4 : ex_pc;
        m_cause[31] = ex_bd;
      end
      m_status[1]  = 1'b1;
      m_cause[6:2] = ex_code;
      if (ex_code == 5'h04 || ex_code == 5'h05) m_badv = ex_badvaddr;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      if (rd == 5'd12) m_status = 32'h0040_0000 | (wdata & 32'h0000_FF03);
      if (rd == 5'd13) m_cause = (m_cause & ~32'h300) | (wdata & 32'h300);
      if (rd == 5'd14) m_epc = wdata;
    end
    m_cause[30]    = ti_new;
    m_cause[15:10] = ip_new;
  endtask

  // One clock of stimulus: queue the expectation for the current cycle, then advance DUT and model.
  task automatic tick(input bit chk, input bit use_c, input logic [31:0] cval, input string tag);
    exp_t e;
    if (chk) begin
      e.rd      = rd;
      e.rdata   = use_c ? cval : model_read(rd);
      e.int_req = model_int();
      e.epc     = m_epc;
      e.exl     = m_status[1];
      e.tag     = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_step();
    #1;
    mtc0_we = 1'b0; ex_valid = 1'b0; eret = 1'b0; reset = 1'b0;
  endtask

  task automatic go(input logic [4:0] r, input string tag);
    rd = r;
    tick(1'b1, 1'b0, 32'h0, tag);
  endtask

  task automatic go_c(input logic [4:0] r, input logic [31:0] v, input string tag);
    rd = r;
    tick(1'b1, 1'b1, v, tag);
  endtask

  task automatic set_mtc0(input logic [4:0] r, input logic [31:0] v);
    mtc0_we = 1'b1; rd = r; wdata = v;
  endtask

  task automatic set_exc(input logic [4:0] c, input logic [31:0] pc, input logic bd, input logic [31:0] bva);
    ex_valid = 1'b1; ex_code = c; ex_pc = pc; ex_bd = bd; ex_badvaddr = bva;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata rd=%0d: got %h want %h", e.tag, e.rd, rdata, e.rdata);
        end
        if (int_req !== e.int_req) begin
          errors++;
          $display("FAIL %s int_req: got %b want %b", e.tag, int_req, e.int_req);
        end
        if (epc_out !== e.epc) begin
          errors++;
          $display("FAIL %s epc_out: got %h want %h", e.tag, epc_out, e.epc);
        end
        if (status_exl !== e.exl) begin
          errors++;
          $display("FAIL %s status_exl: got %b want %b", e.tag, status_exl, e.exl);
        end
        if (e.tag == "reset_cause") begin
          checks++;
          if (exc_target !== 32'hBFC0_0380) begin
            errors++;
            $display("FAIL exc_target: got %h want %h", exc_target, 32'hBFC0_0380);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [4:0]  rd_pool [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10, 5'd31};
    logic [4:0]  wr_pool [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [4:0]  code_pool [7] = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
    int r;

    tick(1'b0, 1'b0, 32'h0, "init");

    // Reset values; TI arms one edge after reset because Count==Compare==0.
    go_c(5'd13, 32'h0, "reset_cause");
    go_c(5'd9, 32'h0, "reset_count");
    go_c(5'd12, 32'h0040_0000, "reset_status");
    go_c(5'd14, 32'h0, "reset_epc");
    set_mtc0(5'd11, 32'hFFFF_0000); go(5'd11, "cmp_far");
    go(5'd13, "ip7_drain0");
    go(5'd13, "ip7_drain1");

    // Exception entry from a delay slot, nested exception, eret.
    set_exc(5'h04, 32'hBFC0_1000, 1'b1, 32'h0000_0003); rd = 5'd0; tick(1'b1, 1'b0, 32'h0, "exc1");
    go_c(5'd14, 32'hBFC0_0FFC, "exc1_epc");
    go_c(5'd13, 32'h8000_0010, "exc1_cause");
    go_c(5'd8, 32'h0000_0003, "exc1_badv");
    go_c(5'd12, 32'h0040_0002, "exc1_status");
    set_exc(5'h0a, 32'h0000_0100, 1'b0, 32'h1234_5678); rd = 5'd0; tick(1'b1, 1'b0, 32'h0, "exc2");
    go_c(5'd14, 32'hBFC0_0FFC, "exc2_epc_hold");
    go_c(5'd8, 32'h0000_0003, "exc2_badv_hold");
    eret = 1'b1; go(5'd12, "eret1");
    go_c(5'd12, 32'h0040_0000, "eret1_status");

    // Priority: exception beats mtc0 EPC; eret beats mtc0 Status.
    set_mtc0(5'd12, 32'h0000_0001); go(5'd12, "ie_on");
    set_exc(5'h08, 32'h0000_2000, 1'b0, 32'h0); set_mtc0(5'd14, 32'hDEAD_BEEF); go(5'd14, "exc_vs_mtc0");
    go_c(5'd14, 32'h0000_2000, "exc_vs_mtc0_epc");
    eret = 1'b1; set_mtc0(5'd12, 32'h0); go(5'd12, "eret_vs_mtc0");
    go_c(5'd12, 32'h0040_0001, "eret_vs_mtc0_status");

    // Timer: Compare=5, Count=0, match after ten clocks, TI then IP7.
    reset = 1'b1; go(5'd0, "timer_reset");
    set_mtc0(5'd11, 32'd5); go(5'd11, "timer_cmp");
    set_mtc0(5'd9, 32'd0); go(5'd9, "timer_cnt");
    for (int k = 1; k <= 10; k++) go(5'd9, "timer_run");
    go_c(5'd9, 32'd5, "timer_count5");
    go_c(5'd13, 32'h4000_0000, "timer_ti");
    go_c(5'd13, 32'h4000_8000, "timer_ip7");
    set_mtc0(5'd12, 32'h0000_8001); go(5'd12, "timer_im7");
    go(5'd13, "timer_intreq");
    set_mtc0(5'd11, 32'd100); go(5'd11, "timer_clr");
    go(5'd13, "timer_clr1");
    go(5'd13, "timer_clr2");
    go(5'd13, "timer_clr3");

    // External interrupt line 0 -> IP2, masked by EXL.
    set_mtc0(5'd12, 32'h0000_0401); go(5'd12, "ext_im2");
    ext_int = 6'b000001; go(5'd13, "ext_rise");
    go(5'd13, "ext_ip2");
    set_exc(5'h00, 32'h0000_3000, 1'b0, 32'h0); go(5'd13, "ext_take");
    go(5'd13, "ext_exl_mask");
    ext_int = 6'b000000;

    // Reset mid-operation with EXL set and Count at its wrap point.
    set_mtc0(5'd9, 32'hFFFF_FFFF); go(5'd9, "mid_cnt");
    go(5'd9, "mid_run");
    reset = 1'b1; go(5'd12, "mid_reset");
    go_c(5'd12, 32'h0040_0000, "mid_status");
    go(5'd9, "mid_count0");
    go_c(5'd14, 32'h0, "mid_epc");
    for (int k = 0; k < 4; k++) go(5'd9, "mid_count_run");

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      r  = $urandom_range(0, 99);
      rd = rd_pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) ext_int = 6'($urandom);
      if (r < 2) begin
        reset = 1'b1;
      end else if (r < 12) begin
        set_exc(code_pool[$urandom_range(0, 6)], $urandom, 1'($urandom), $urandom);
        if ($urandom_range(0, 2) == 0) eret = 1'b1;
        if ($urandom_range(0, 2) == 0) begin mtc0_we = 1'b1; wdata = $urandom; end
      end else if (r < 20) begin
        eret = 1'b1;
        if ($urandom_range(0, 1) == 0) begin mtc0_we = 1'b1; wdata = $urandom; end
      end else if (r < 45) begin
        mtc0_we = 1'b1;
        rd = wr_pool[$urandom_range(0, 4)];
        case (rd)
          5'd9:    wdata = ($urandom_range(0, 1) == 0) ? m_compare - 32'($urandom_range(0, 4)) : 32'hFFFF_FFFE;
          5'd11:   wdata = m_count + 32'($urandom_range(0, 8));
          default: wdata = $urandom;
        endcase
      end
      tick(1'b1, 1'b0, 32'h0, "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Sequential MIPS CP0 register file and exception controller, sitting beside the MEM/WB boundary.
- Owns BadVAddr, Count, Compare, Status, Cause and EPC. Serves mtc0 writes and mfc0 reads.
- Records exception entry and eret, runs the Count/Compare timer, and raises the interrupt request consumed by the pipeline flush logic.
- Replaces the ad hoc combinational CP0 capture in the MEM stage with one authoritative, clocked state holder.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, exception entry PC driven on exc_target
COUNT_DIV, 2, clocks per Count increment (must be >=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
mtc0_we  in  1  write rd with wdata this cycle
rd  in  5  CP0 register number for mtc0/mfc0 (8,9,11,12,13,14 implemented)
wdata  in  32  mtc0 write data (GPR rt value)
rdata  out  32  combinational mfc0 read of register rd; 0 for unimplemented rd
ex_valid  in  1  exception committed this cycle
ex_code  in  5  ExcCode of committed exception
ex_pc  in  32  PC of faulting instruction
ex_bd  in  1  faulting instruction is in a delay slot
ex_badvaddr  in  32  faulting address (used for AdEL/AdES only)
eret  in  1  eret committed this cycle
ext_int  in  6  hardware interrupt lines, level-sensitive
epc_out  out  32  current EPC (eret target)
exc_target  out  32  constant EXC_VECTOR
status_exl  out  1  Status.EXL
int_req  out  1  interrupt pending and enabled

Behaviour:
- Reset values:
  - BadVAddr, Count, Compare, Cause, EPC = 0.
  - Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - Internal divider count = 0.
  - Hence int_req=0, status_exl=0, epc_out=0.
- Update priority within a cycle: reset > ex_valid > eret > mtc0_we. A suppressed mtc0 has no effect.
- Status:
  - Writable bits: IM[15:8], EXL[1], IE[0].
  - BEV[22] reads constant 1. All other bits read 0.
- Cause:
  - Writable by mtc0: only IP[9:8] (software interrupts).
  - IP[15:10] = {TI | ext_int[5], ext_int[4:0]}, registered every cycle (one-cycle sample latency).
  - TI[30], BD[31], ExcCode[6:2] are hardware-only.
- Exception entry (ex_valid=1):
  - If EXL=0: EPC <= ex_bd ? ex_pc-4 : ex_pc (32-bit wrap); Cause.BD <= ex_bd.
  - If EXL=1: EPC and BD hold.
  - In both cases: EXL <= 1; ExcCode <= ex_code.
  - BadVAddr <= ex_badvaddr only when ex_code is AdEL(5'h04) or AdES(5'h05).
  - For interrupt entry the pipeline supplies ex_code=5'h00.
- eret: EXL <= 0. All other state is unchanged.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count increments by 1 when the divider wraps. Count wraps 32'hFFFF_FFFF -> 0.
  - mtc0 to Count loads wdata and overrides that cycle's increment. The divider is not reset.
  - TI sets the cycle after Count==Compare (registered compare).
  - mtc0 to Compare clears TI. If set and clear fall in the same cycle, clear wins.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]). Combinational from registers; no input-to-output path.
- rdata: pure combinational mux on rd. A write in cycle N is visible on rdata in cycle N+1; there is no same-cycle bypass.
- Reset asserted mid-operation (EXL=1, timer running) returns every register to its reset value at the next edge.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers (CP0_BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14);
  - ExcCode constants (INT, ADEL, ADES, SYS, BP, RI, OV);
  - Status/Cause bit-position localparams and the Status reset constant.
- One sub-module, cp0_timer, covers the divider, Count, Compare and TI, with Count/Compare write ports and TI clear. Everything else stays in cp0_regfile.

Test Plan:
- Reset, then read rd=12,13,14,9 -> rdata 32'h0040_0000, 0, 0, 0; int_req=0.
- ex_valid with ex_code=5'h04, ex_pc=32'hBFC0_1000, ex_bd=1, ex_badvaddr=32'h0000_0003 -> next cycle EPC=32'hBFC0_0FFC, Cause=32'h8000_0010, BadVAddr=32'h3, EXL=1. A second exception with ex_pc=32'h100 leaves EPC unchanged. eret -> EXL=0.
- mtc0 Compare=5, Count=0, COUNT_DIV=2 -> Count reaches 5 after 10 clocks and TI=1 one cycle later. Then mtc0 Status=32'h0000_8001 -> int_req=1. mtc0 Compare=100 -> TI=0, int_req=0.
- ext_int=6'b000001, Status=32'h0000_0401 -> Cause.IP2=1 and int_req=1 one cycle after ext_int rises. With EXL=1, int_req=0.
- Same cycle ex_valid and mtc0 EPC=32'hDEAD_BEEF -> EPC takes exception value, not 32'hDEAD_BEEF. Same cycle eret and mtc0 Status=0 -> EXL=0, IE unchanged.
- Assert reset while EXL=1, Count=32'hFFFF_FFFF -> next cycle all registers at reset values; Count then counts from 0.
